// File: rtl/nv_fifo_ctrl_pkg.sv
// Shared constants and pointer-wrap helper for the 80x17 FIFO controller.
// DEPTH is not a power of two, so pointers wrap explicitly at DEPTH-1.
package nv_fifo_ctrl_pkg;

    localparam int DEPTH = 80;
    localparam int WIDTH = 17;
    localparam int AW    = 7;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

endpackage

// File: rtl/nv_fifo_ctrl_80x17_ptr.sv
// AW-bit RAM address counter that advances on inc and wraps DEPTH-1 -> 0.
// Used once for the write pointer and once for the read pointer.
module nv_fifo_ptr
    import nv_fifo_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
            ptr <= next_ptr(ptr);
        end
    end

endmodule

// File: rtl/nv_fifo_ctrl_80x17.sv
// Valid/ready FIFO controller sequencing an 80x17 two-port RAM with a registered
// read address and a bypass-capable output register that holds rd_pd.
module nv_fifo_ctrl_80x17
    import nv_fifo_ctrl_pkg::*;
(
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic             ram_we,
    output logic [AW-1:0]    ram_wa,
    output logic [WIDTH-1:0] ram_di,
    output logic             ram_re,
    output logic [AW-1:0]    ram_ra,
    output logic             ram_ore,
    output logic             ram_byp_sel,
    output logic [WIDTH-1:0] ram_dbyp,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [AW-1:0]    fifo_cnt,
    output logic             fifo_idle
);

    logic          s1_vld;
    logic          out_free;
    logic          s1_adv;
    logic          wr_push;
    logic          bypass;
    logic [AW-1:0] unread;

    assign wr_prdy  = (fifo_cnt < AW'(DEPTH));
    assign wr_push  = wr_pvld && wr_prdy;
    assign out_free = !rd_pvld || rd_prdy;
    assign s1_adv   = s1_vld && out_free;
    assign unread   = fifo_cnt - AW'(s1_vld);

    assign ram_di      = wr_pd;
    assign ram_dbyp    = wr_pd;
    assign ram_byp_sel = bypass;
    assign rd_pd       = ram_dout;
    assign fifo_idle   = (fifo_cnt == '0) && !rd_pvld && !s1_vld;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        bypass  = 1'b0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        ram_ore = 1'b0;
        if (!nvdla_core_rst) begin
            bypass  = wr_push && (fifo_cnt == '0) && !s1_vld && out_free;
            ram_we  = wr_push && !bypass;
            // Only entries written on an earlier edge are counted in unread.
            ram_re  = (unread != '0) && (!s1_vld || s1_adv);
            ram_ore = s1_adv || bypass;
        end
    end

    nv_fifo_ptr u_wr_ptr (
        .clk (nvdla_core_clk),
        .rst (nvdla_core_rst),
        .inc (ram_we),
        .ptr (ram_wa)
    );

    nv_fifo_ptr u_rd_ptr (
        .clk (nvdla_core_clk),
        .rst (nvdla_core_rst),
        .inc (ram_re),
        .ptr (ram_ra)
    );

    // A slot is released on s1_adv, when the RAM array is read into the output register.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            s1_vld   <= 1'b0;
            rd_pvld  <= 1'b0;
            fifo_cnt <= '0;
        end else begin
            s1_vld   <= ram_re || (s1_vld && !s1_adv);
            rd_pvld  <= ram_ore || (rd_pvld && !rd_prdy);
            fifo_cnt <= fifo_cnt + AW'(ram_we) - AW'(s1_adv);
        end
    end

endmodule
